// File: rtl/sync_ram_pkg.sv
// Shared types and the byte-merge helper for sync_dual_ram.
// Used by both the write path and the SYNC_DUAL_RAM_BYPASS_EN forwarding path.
package sync_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // Widest word the merge helper handles; callers cast their word to this width and back.
  localparam int MERGE_W    = 512;
  localparam int MERGE_BE_W = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0]    old_w,
    input logic [MERGE_W-1:0]    new_w,
    input logic [MERGE_BE_W-1:0] be
  );
    logic [MERGE_W-1:0] res;
    res = old_w;
    for (int k = 0; k < MERGE_BE_W; k++) begin
      if (be[k]) begin
        res[8*k +: 8] = new_w[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_w[8*k +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_ram_clr_seq.sv
// Controller FSM and sweep counter for sync_dual_ram: walks every address once
// after clr or clr_mem, reporting busy and the clear-write address.
module sync_ram_clr_seq
  import sync_ram_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              clr_mem_i,
  output logic              busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_ad_o
);

  localparam logic [ADDR_W-1:0] LAST_AD = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q <= CLEAR;
      cnt_q   <= {ADDR_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        if (cnt_q == LAST_AD) begin
          state_d = READY;
          cnt_d   = {ADDR_W{1'b0}};
        end else begin
          cnt_d   = cnt_q + ADDR_W'(1);
        end
      end
      READY: begin
        if (clr_mem_i) begin
          state_d = CLEAR;
          cnt_d   = {ADDR_W{1'b0}};
        end else begin
          state_d = READY;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Outputs decode straight from state registers, so they carry no combinational input path.
  assign busy_o   = (state_q == CLEAR);
  assign clr_we_o = (state_q == CLEAR);
  assign clr_ad_o = cnt_q;

endmodule

// File: rtl/sync_dual_ram.sv
// Single-clock simple dual-port RAM with byte enables, registered read and clear sweep.
// Define SYNC_DUAL_RAM_BYPASS_EN for write-first collisions; default is read-first.
module sync_dual_ram
  import sync_ram_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              clr_mem,
  output logic              busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_ad,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_ad,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] data_out_q;
  logic              rd_valid_q;

  logic              busy_s;
  logic              clr_we_s;
  logic [ADDR_W-1:0] clr_ad_s;
  logic              wr_in_range_s;
  logic              rd_in_range_s;
  logic [DATA_W-1:0] wr_merge_s;
  logic [DATA_W-1:0] rd_word_s;

  sync_ram_clr_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk_i     (clk),
    .clr_i     (clr),
    .clr_mem_i (clr_mem),
    .busy_o    (busy_s),
    .clr_we_o  (clr_we_s),
    .clr_ad_o  (clr_ad_s)
  );

  assign wr_in_range_s = ({1'b0, wr_ad} < DEPTH_C);
  assign rd_in_range_s = ({1'b0, rd_ad} < DEPTH_C);
  assign wr_merge_s    = DATA_W'(byte_merge(MERGE_W'(mem_q[wr_ad]), MERGE_W'(data_in),
                                            MERGE_BE_W'(wr_be)));

  always_comb begin
    rd_word_s = {DATA_W{1'b0}};
    if (rd_in_range_s) begin
      rd_word_s = mem_q[rd_ad];
    end else begin
      rd_word_s = {DATA_W{1'b0}};
    end
`ifdef SYNC_DUAL_RAM_BYPASS_EN
    if (wr_en && rd_in_range_s && (wr_ad == rd_ad)) begin
      rd_word_s = wr_merge_s;
    end else begin
      rd_word_s = rd_word_s;
    end
`endif
  end

  // The sweep owns the write port while busy; clr blocks every write on its edge.
  always_ff @(posedge clk) begin
    if (!clr) begin
      if (clr_we_s) begin
        mem_q[clr_ad_s] <= {DATA_W{1'b0}};
      end else if (wr_en && wr_in_range_s) begin
        mem_q[wr_ad] <= wr_merge_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      data_out_q <= {DATA_W{1'b0}};
      rd_valid_q <= 1'b0;
    end else if (busy_s) begin
      rd_valid_q <= 1'b0;
    end else if (rd_en) begin
      data_out_q <= rd_word_s;
      rd_valid_q <= 1'b1;
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  assign busy     = busy_s;
  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_sync_dual_ram.sv
// Scoreboard bench for sync_dual_ram: instance a (DEPTH=8) and instance b (DEPTH=6).
// Collision expectations follow SYNC_DUAL_RAM_BYPASS_EN.
module tb_sync_dual_ram;

`ifdef SYNC_DUAL_RAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_clr, a_clr_mem, a_busy, a_wr_en, a_rd_en, a_rd_valid;
  logic [2:0]  a_wr_ad, a_rd_ad;
  logic [1:0]  a_wr_be;
  logic [15:0] a_din, a_dout;
  logic        b_clr, b_clr_mem, b_busy, b_wr_en, b_rd_en, b_rd_valid;
  logic [2:0]  b_wr_ad, b_rd_ad;
  logic [1:0]  b_wr_be;
  logic [15:0] b_din, b_dout;

  sync_dual_ram #(.DATA_W(16), .DEPTH(8)) dut_a (
    .clk(clk), .clr(a_clr), .clr_mem(a_clr_mem), .busy(a_busy),
    .wr_en(a_wr_en), .wr_ad(a_wr_ad), .wr_be(a_wr_be), .data_in(a_din),
    .rd_en(a_rd_en), .rd_ad(a_rd_ad), .data_out(a_dout), .rd_valid(a_rd_valid)
  );

  sync_dual_ram #(.DATA_W(16), .DEPTH(6)) dut_b (
    .clk(clk), .clr(b_clr), .clr_mem(b_clr_mem), .busy(b_busy),
    .wr_en(b_wr_en), .wr_ad(b_wr_ad), .wr_be(b_wr_be), .data_in(b_din),
    .rd_en(b_rd_en), .rd_ad(b_rd_ad), .data_out(b_dout), .rd_valid(b_rd_valid)
  );

  int tests  = 0;
  int errors = 0;

  logic [15:0] qa[$];
  string       na[$];
  logic [15:0] qb[$];
  string       nb[$];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every rd_valid pulse pops one expectation from its instance queue.
  always @(negedge clk) begin
    if (a_rd_valid === 1'b1) begin
      if (qa.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL a_unexpected_valid: got rd_valid=1 data=%h, expected no read", a_dout);
      end else begin
        check(na.pop_front(), a_dout, qa.pop_front());
      end
    end
    if (b_rd_valid === 1'b1) begin
      if (qb.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL b_unexpected_valid: got rd_valid=1 data=%h, expected no read", b_dout);
      end else begin
        check(nb.pop_front(), b_dout, qb.pop_front());
      end
    end
  end

  task automatic op_a(input logic wr, input logic [2:0] wad, input logic [1:0] be,
                      input logic [15:0] din, input logic rd, input logic [2:0] rad,
                      input logic [15:0] exp, input string nm);
    @(negedge clk);
    a_wr_en = wr; a_wr_ad = wad; a_wr_be = be; a_din = din;
    a_rd_en = rd; a_rd_ad = rad;
    if (rd) begin
      qa.push_back(exp);
      na.push_back(nm);
    end
  endtask

  task automatic op_b(input logic wr, input logic [2:0] wad, input logic [1:0] be,
                      input logic [15:0] din, input logic rd, input logic [2:0] rad,
                      input logic [15:0] exp, input string nm);
    @(negedge clk);
    b_wr_en = wr; b_wr_ad = wad; b_wr_be = be; b_din = din;
    b_rd_en = rd; b_rd_ad = rad;
    if (rd) begin
      qb.push_back(exp);
      nb.push_back(nm);
    end
  endtask

  // Called on the negedge right after the clear request was sampled; hammers both ports meanwhile.
  task automatic count_busy_a(input string nm, input int exp_n, input logic [15:0] hold);
    int n = 0;
    for (int i = 0; i < 20; i++) begin
      if (a_busy !== 1'b1) break;
      n++;
      check({nm, "_hold"}, a_dout, hold);
      a_rd_en = 1'b1; a_rd_ad = 3'(i % 8);
      a_wr_en = 1'b1; a_wr_ad = 3'(i % 8); a_wr_be = 2'b11; a_din = 16'hFFFF;
      @(negedge clk);
    end
    a_rd_en = 1'b0;
    a_wr_en = 1'b0;
    check({nm, "_busy_cycles"}, 16'(n), 16'(exp_n));
  endtask

  task automatic read_all_a_zero(input string nm);
    for (int i = 0; i < 8; i++) op_a(1'b0, 3'd0, 2'b00, 16'h0000, 1'b1, 3'(i), 16'h0000, nm);
    op_a(1'b0, 3'd0, 2'b00, 16'h0000, 1'b0, 3'd0, 16'h0000, "");
  endtask

  initial begin
    a_clr = 1'b1; a_clr_mem = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0;
    a_wr_ad = 3'd0; a_rd_ad = 3'd0; a_wr_be = 2'b00; a_din = 16'h0000;
    b_clr = 1'b1; b_clr_mem = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0;
    b_wr_ad = 3'd0; b_rd_ad = 3'd0; b_wr_be = 2'b00; b_din = 16'h0000;
    repeat (2) @(negedge clk);
    a_clr = 1'b0;
    b_clr = 1'b0;
    check("reset_busy", 16'(a_busy), 16'h0001);
    check("reset_rd_valid", 16'(a_rd_valid), 16'h0000);
    check("reset_b_busy", 16'(b_busy), 16'h0001);
    count_busy_a("reset", 8, 16'h0000);
    read_all_a_zero("reset_read");

    // Byte enables
    op_a(1'b1, 3'd3, 2'b11, 16'hAAAA, 1'b0, 3'd0, 16'h0000, "");
    op_a(1'b1, 3'd3, 2'b01, 16'h55FF, 1'b0, 3'd0, 16'h0000, "");
    op_a(1'b0, 3'd0, 2'b00, 16'h0000, 1'b1, 3'd3, 16'hAAFF, "byte_enable");
    op_a(1'b1, 3'd3, 2'b00, 16'h1111, 1'b0, 3'd0, 16'h0000, "");
    op_a(1'b0, 3'd0, 2'b00, 16'h0000, 1'b1, 3'd3, 16'hAAFF, "be_zero_noop");

    // Same-address collisions, full and partial
    op_a(1'b1, 3'd5, 2'b11, 16'h1234, 1'b0, 3'd0, 16'h0000, "");
    op_a(1'b1, 3'd5, 2'b11, 16'hBEEF, 1'b1, 3'd5, BYP ? 16'hBEEF : 16'h1234, "collision_full");
    op_a(1'b0, 3'd0, 2'b00, 16'h0000, 1'b1, 3'd5, 16'hBEEF, "collision_after");
    op_a(1'b1, 3'd5, 2'b01, 16'h00CD, 1'b1, 3'd5, BYP ? 16'hBECD : 16'hBEEF, "collision_part");
    op_a(1'b0, 3'd0, 2'b00, 16'h0000, 1'b1, 3'd5, 16'hBECD, "collision_part_after");

    // clr_mem holds data_out and ignores accesses while busy
    for (int i = 0; i < 8; i++) op_a(1'b1, 3'(i), 2'b11, 16'h1000 + 16'(i), 1'b0, 3'd0, 16'h0000, "");
    op_a(1'b1, 3'd6, 2'b11, 16'h00C3, 1'b0, 3'd0, 16'h0000, "");
    op_a(1'b0, 3'd0, 2'b00, 16'h0000, 1'b1, 3'd2, 16'h1002, "fill_read");
    op_a(1'b0, 3'd0, 2'b00, 16'h0000, 1'b1, 3'd6, 16'h00C3, "fill_read_c3");
    op_a(1'b0, 3'd0, 2'b00, 16'h0000, 1'b0, 3'd0, 16'h0000, "");
    a_clr_mem = 1'b1;
    @(negedge clk);
    a_clr_mem = 1'b0;
    count_busy_a("clr_mem", 8, 16'h00C3);
    read_all_a_zero("clr_mem_read");

    // Mid-sweep clr restarts the sweep from address 0
    for (int i = 4; i < 8; i++) op_a(1'b1, 3'(i), 2'b11, 16'h4200 + 16'(i), 1'b0, 3'd0, 16'h0000, "");
    op_a(1'b0, 3'd0, 2'b00, 16'h0000, 1'b1, 3'd7, 16'h4207, "pre_sweep_read");
    op_a(1'b0, 3'd0, 2'b00, 16'h0000, 1'b0, 3'd0, 16'h0000, "");
    a_clr_mem = 1'b1;
    @(negedge clk);
    a_clr_mem = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_sweep_busy_before", 16'(a_busy), 16'h0001);
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    check("mid_sweep_dout_reset", a_dout, 16'h0000);
    count_busy_a("mid_sweep", 8, 16'h0000);
    read_all_a_zero("mid_sweep_read");

    // DEPTH=6 boundary on instance b
    check("b_idle_after_reset", 16'(b_busy), 16'h0000);
    op_b(1'b0, 3'd0, 2'b00, 16'h0000, 1'b0, 3'd0, 16'h0000, "");
    b_clr = 1'b1;
    @(negedge clk);
    b_clr = 1'b0;
    begin
      int n = 0;
      for (int i = 0; i < 20; i++) begin
        if (b_busy !== 1'b1) break;
        n++;
        @(negedge clk);
      end
      check("b_busy_cycles", 16'(n), 16'd6);
    end
    op_b(1'b1, 3'd0, 2'b11, 16'h0A0A, 1'b0, 3'd0, 16'h0000, "");
    op_b(1'b1, 3'd5, 2'b11, 16'h5050, 1'b0, 3'd0, 16'h0000, "");
    op_b(1'b1, 3'd6, 2'b11, 16'h7777, 1'b0, 3'd0, 16'h0000, "");
    op_b(1'b1, 3'd7, 2'b11, 16'h8888, 1'b0, 3'd0, 16'h0000, "");
    op_b(1'b0, 3'd0, 2'b00, 16'h0000, 1'b1, 3'd6, 16'h0000, "b_read_oor6");
    op_b(1'b0, 3'd0, 2'b00, 16'h0000, 1'b1, 3'd0, 16'h0A0A, "b_read_addr0");
    op_b(1'b0, 3'd0, 2'b00, 16'h0000, 1'b1, 3'd5, 16'h5050, "b_read_addr5");
    op_b(1'b0, 3'd0, 2'b00, 16'h0000, 1'b1, 3'd7, 16'h0000, "b_read_oor7");
    op_b(1'b0, 3'd0, 2'b00, 16'h0000, 1'b1, 3'd1, 16'h0000, "b_read_addr1");
    op_b(1'b0, 3'd0, 2'b00, 16'h0000, 1'b0, 3'd0, 16'h0000, "");

    repeat (3) @(negedge clk);
    check("a_queue_drained", 16'(qa.size()), 16'h0000);
    check("b_queue_drained", 16'(qb.size()), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sync_dual_ram.md
# sync_dual_ram

Parametrised single-clock simple dual-port RAM with one write port and one registered read port. It adds per-byte write enables, a read-valid strobe, a sequenced memory-clear engine and optional same-address write-to-read forwarding. It serves as the general-purpose buffer for FIFOs and packet stores where both sides share one clock domain.

## Interface
Parameters:
- DATA_W, 16, data width in bits; must be a multiple of 8.
- DEPTH, 8, number of words; any value ≥ 2, not necessarily a power of two.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- BE_W, DATA_W/8, byte-enable width; derived.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- clr  in  1  reset, synchronous, active-high.
- clr_mem  in  1  request a full memory clear without resetting the read path.
- busy  out  1  clear sweep in progress.
- wr_en  in  1  write strobe.
- wr_ad  in  ADDR_W  write address.
- wr_be  in  BE_W  byte enables; bit k covers data_in[8k+7:8k].
- data_in  in  DATA_W  write data.
- rd_en  in  1  read strobe.
- rd_ad  in  ADDR_W  read address.
- data_out  out  DATA_W  registered read data.
- rd_valid  out  1  data_out updated this cycle.

## Operation
- Controller FSM, two states: CLEAR and READY.
- clr sampled high: data_out←0, rd_valid←0, busy←1, sweep counter←0, state←CLEAR. clr has priority over every other input.
- clr_mem sampled high in READY: state←CLEAR, counter←0, busy←1. data_out holds its value. clr_mem is ignored while already in CLEAR.
- CLEAR: writes 0 to mem[counter] each cycle and increments the counter. After the write to address DEPTH-1, state←READY and busy←0. The sweep takes exactly DEPTH cycles.
- In CLEAR, wr_en and rd_en are ignored. No write occurs and rd_valid stays 0.
- clr asserted mid-sweep restarts the sweep at address 0.
- READY write: for each k with wr_be[k]=1, mem[wr_ad] byte k←data_in byte k. Other bytes are unchanged. wr_be=0 is a no-op.
- READY read: data_out←mem[rd_ad] and rd_valid←1. With no read, data_out holds and rd_valid←0.
- Out-of-range address (≥ DEPTH):
  - Write is dropped.
  - Read returns 0 with rd_valid=1.
- Same-address read and write in one cycle: the result depends on the configuration macro (see Configuration).

## Timing
- Read latency is 1 cycle. rd_en sampled at edge N gives data_out and rd_valid valid after edge N for one cycle.
- Write visible to reads sampled from edge N+1 onward.
- busy rises the cycle after clr/clr_mem is sampled. It falls after edge DEPTH of the sweep, so the first accepted access is on the following edge.
- Reset values: data_out=0, rd_valid=0, busy=1. Memory contents are all-zero DEPTH cycles after reset.

## Configuration
- SYNC_DUAL_RAM_BYPASS_EN defined: on a same-address read/write collision, data_out returns the old word merged with the enabled new bytes (write-first).
- Undefined: on a collision, data_out returns the pre-write word (read-first). The write still completes.

## Structure
- Shared package sync_ram_pkg holds:
  - the state enum (CLEAR, READY);
  - the byte-merge function (old word, new word, byte enables → merged word), shared by the write path and the bypass path.
- Sub-module sync_ram_clr_seq contains the FSM and sweep counter. Outputs: busy, clear-write enable, clear address.
- The storage array and read register stay in the top module.

## Test plan
- Reset, DEPTH=8: pulse clr for 1 cycle → busy=1 for 8 cycles, then 0. Reads of all addresses return 0 with rd_valid=1.
- Byte enables: write 0xAAAA with be=2'b11 at address 3, then 0x55FF with be=2'b01 → read of address 3 returns 0xAAFF, 1 cycle later.
- Collision: mem[5]=0x1234, then write 0xBEEF be=2'b11 and read address 5 in the same cycle → 0xBEEF with the macro, 0x1234 without. The next read returns 0xBEEF in both builds.
- clr_mem: fill memory, hold data_out=0x00C3, pulse clr_mem → data_out stays 0x00C3. rd_en/wr_en issued during busy are ignored. Afterwards all words read 0.
- Mid-sweep reset: assert clr at sweep cycle 4 → busy stays high for 8 further cycles.
- DEPTH=6 boundary: write address 6 is dropped, read of address 6 returns 0. Addresses 0 and 5 write and read correctly.
